// File: rtl/i2s_tx_sequencer.sv
// I2S (Philips) transmit sequencer: stereo sample FIFO, SCK/WS divider
// and MSB-first serialiser feeding the exported i2s_sck/i2s_ws/i2s_sd pins.
module i2s_tx_sequencer #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CDW   = 8,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [CDW-1:0] clk_div,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [2*DW-1:0] s_data,
    output logic          i2s_sck,
    output logic          i2s_ws,
    output logic          i2s_sd,
    output logic          busy,
    output logic          underrun,
    output logic [LW-1:0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = 2 * DW;
    localparam int BW = $clog2(FW);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [CDW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] nbit;
    logic [FW-1:0] shreg;
    logic [FW-1:0] head;
    logic          sck_q;
    logic          ws_q;
    logic          underrun_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          tick;
    logic          fall;
    logic          wrap;
    logic          start;

    assign s_ready    = level < LW'(DEPTH);
    assign push       = s_valid & s_ready;
    assign fifo_empty = level == '0;
    assign head       = mem[rd_ptr];

    assign tick  = div_cnt >= clk_div;
    assign fall  = (state == RUN) && tick && sck_q;
    assign wrap  = bit_cnt == BW'(FW - 1);
    assign nbit  = wrap ? '0 : bit_cnt + BW'(1);
    assign start = (state == IDLE) && enable && !fifo_empty;
    // Boundary pops only when running on; an empty FIFO is an underrun, not a pop
    assign pop   = start | (fall & wrap & enable & !fifo_empty);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    sck_q   <= 1'b0;
                    ws_q    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (start) begin
                        state <= RUN;
                        shreg <= head;
                    end
                end
                RUN: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + CDW'(1);
                    end else begin
                        div_cnt <= '0;
                        sck_q   <= ~sck_q;
                        if (sck_q) begin
                            bit_cnt <= nbit;
                            // WS leads the channel MSB by one bit
                            ws_q <= (nbit >= BW'(DW - 1)) &&
                                    (nbit <= BW'(FW - 2));
                            if (!wrap) begin
                                shreg <= shreg << 1;
                            end else if (!enable) begin
                                state <= IDLE;
                                sck_q <= 1'b0;
                                ws_q  <= 1'b0;
                                shreg <= '0;
                            end else if (fifo_empty) begin
                                shreg      <= '0;
                                underrun_q <= 1'b1;
                            end else begin
                                shreg <= head;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i2s_sck    = sck_q;
    assign i2s_ws     = ws_q;
    assign i2s_sd     = shreg[FW-1];
    assign busy       = state == RUN;
    assign underrun   = underrun_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: scoreboard of pushed stereo words
// compared against frames captured on SCK rising edges.
module tb_i2s_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  clk_div = 8'd1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        i2s_sck;
    logic        i2s_ws;
    logic        i2s_sd;
    logic        busy;
    logic        underrun;
    logic [2:0]  fifo_level;

    i2s_tx_sequencer #(.DW(16), .DEPTH(4), .CDW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clk_div    (clk_div),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .i2s_sck    (i2s_sck),
        .i2s_ws     (i2s_ws),
        .i2s_sd     (i2s_sd),
        .busy       (busy),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    longint      cyc = 0;
    logic        prev_sck = 1'b0;
    logic        rise = 1'b0;
    logic        tog = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] ws_exp;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tog = (i2s_sck !== prev_sck);
        rise = i2s_sck & ~prev_sck;
        prev_sck = i2s_sck;
    endtask

    task automatic push_word(input logic [31:0] w);
        int k;
        s_valid = 1'b1;
        s_data = w;
        k = 0;
        while (!s_ready && k < 2000) begin
            step();
            k++;
        end
        chk("push_timeout", 64'(s_ready), 64'd1);
        exp_q.push_back(w);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 2000) begin
            step();
            k++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic capture(input int drop_at, input string tag,
                           output longint first_rise, output longint gap,
                           output int urs, output int idles);
        int n;
        int k;
        longint last;
        logic [31:0] d;
        logic [31:0] w;
        logic [31:0] exp;
        n = 0; k = 0; urs = 0; idles = 0;
        d = '0; w = '0; last = 0; gap = 0; first_rise = 0;
        while (n < 32 && k < 4000) begin
            step();
            k++;
            if (underrun) urs++;
            if (!busy) idles++;
            if (rise) begin
                if (n == 0) first_rise = cyc;
                else gap = cyc - last;
                last = cyc;
                d = {d[30:0], i2s_sd};
                w = {w[30:0], i2s_ws};
                n++;
                if (n == drop_at) enable = 1'b0;
            end
        end
        chk({tag, "_bits"}, 64'(n), 64'd32);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        chk({tag, "_data"}, 64'(d), 64'(exp));
        chk({tag, "_ws"}, 64'(w), 64'(ws_exp));
    endtask

    initial begin
        longint t_entry;
        longint r1;
        longint r2;
        longint gap;
        int     urs;
        int     idles;
        int     tot_urs;
        int     tot_idle;
        int     toggles;
        int     steps;
        int     rises;
        logic [31:0] words [5];

        // WS level seen at the rising edge of frame bit i: high for i=15..30
        ws_exp = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= 15 && i <= 30) ws_exp[31-i] = 1'b1;
        end

        // T1 reset
        step();
        step();
        chk("t1_sck", 64'(i2s_sck), 64'd0);
        chk("t1_ws", 64'(i2s_ws), 64'd0);
        chk("t1_sd", 64'(i2s_sd), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_underrun", 64'(underrun), 64'd0);
        chk("t1_level", 64'(fifo_level), 64'd0);
        chk("t1_ready", 64'(s_ready), 64'd1);
        reset = 1'b0;
        step();

        // T2 single frame, clk_div=1
        clk_div = 8'd1;
        push_word(32'hA5A5_0F0F);
        chk("t2_level", 64'(fifo_level), 64'd1);
        chk("t2_idle", 64'(busy), 64'd0);
        enable = 1'b1;
        step();
        t_entry = cyc;
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_popped", 64'(fifo_level), 64'd0);
        chk("t2_sd_msb", 64'(i2s_sd), 64'd1);
        capture(-1, "t2", r1, gap, urs, idles);
        chk("t2_latency", 64'(r1 - t_entry), 64'd2);
        chk("t2_sck_period", 64'(gap), 64'd4);
        chk("t2_no_underrun", 64'(urs), 64'd0);

        // T3 underrun frame
        capture(-1, "t3", r2, gap, urs, idles);
        enable = 1'b0;
        chk("t3_frame_len", 64'(r2 - r1), 64'd128);
        chk("t3_underrun_once", 64'(urs), 64'd1);
        chk("t3_busy_held", 64'(idles), 64'd0);
        wait_idle();
        chk("t3_sck_idle", 64'(i2s_sck), 64'd0);
        chk("t3_no_extra_pulse", 64'(underrun), 64'd0);

        // T4 full FIFO
        words[0] = 32'h1234_8765;
        words[1] = 32'hFFFF_0001;
        words[2] = 32'h8000_7FFF;
        words[3] = 32'h0F0F_F0F0;
        words[4] = 32'hC3C3_3C3C;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = words[i];
            chk("t4_ready", 64'(s_ready), 64'd1);
            exp_q.push_back(words[i]);
            step();
        end
        s_data = words[4];
        chk("t4_full_ready", 64'(s_ready), 64'd0);
        chk("t4_full_level", 64'(fifo_level), 64'd4);
        step();
        step();
        chk("t4_held_level", 64'(fifo_level), 64'd4);
        enable = 1'b1;
        step();
        chk("t4_pop_level", 64'(fifo_level), 64'd3);
        chk("t4_pop_ready", 64'(s_ready), 64'd1);
        step();
        chk("t4_fifth_in", 64'(fifo_level), 64'd4);
        exp_q.push_back(words[4]);
        s_valid = 1'b0;
        tot_urs = 0;
        tot_idle = 0;
        for (int i = 0; i < 5; i++) begin
            capture(-1, "t4", r1, gap, urs, idles);
            tot_urs += urs;
            tot_idle += idles;
        end
        enable = 1'b0;
        chk("t4_no_underrun", 64'(tot_urs), 64'd0);
        chk("t4_busy_held", 64'(tot_idle), 64'd0);
        wait_idle();
        chk("t4_empty", 64'(fifo_level), 64'd0);

        // T5 stop mid-frame
        push_word(32'h6B6B_9D9D);
        push_word(32'h2468_ACE0);
        enable = 1'b1;
        step();
        capture(6, "t5", r1, gap, urs, idles);
        chk("t5_enable_dropped", 64'(enable), 64'd0);
        wait_idle();
        chk("t5_sck", 64'(i2s_sck), 64'd0);
        chk("t5_ws", 64'(i2s_ws), 64'd0);
        chk("t5_sd", 64'(i2s_sd), 64'd0);
        chk("t5_level", 64'(fifo_level), 64'd1);
        chk("t5_underrun", 64'(urs), 64'd0);

        // T6 clk_div=0 and reset mid-frame
        clk_div = 8'd0;
        push_word(32'h5555_AAAA);
        enable = 1'b1;
        step();
        chk("t6_busy", 64'(busy), 64'd1);
        toggles = 0;
        steps = 0;
        rises = 0;
        while (rises < 11 && steps < 200) begin
            step();
            steps++;
            if (tog) toggles++;
            if (rise) rises++;
        end
        chk("t6_rises", 64'(rises), 64'd11);
        chk("t6_toggle_every_clk", 64'(toggles), 64'(steps));
        chk("t6_level_before", 64'(fifo_level), 64'd1);
        reset = 1'b1;
        step();
        chk("t6_sck", 64'(i2s_sck), 64'd0);
        chk("t6_ws", 64'(i2s_ws), 64'd0);
        chk("t6_sd", 64'(i2s_sd), 64'd0);
        chk("t6_busy_low", 64'(busy), 64'd0);
        chk("t6_underrun", 64'(underrun), 64'd0);
        chk("t6_level", 64'(fifo_level), 64'd0);
        chk("t6_ready", 64'(s_ready), 64'd1);
        reset = 1'b0;
        enable = 1'b0;
        exp_q.delete();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
